debug_mem_sequencer: RTL and testbench

//  Post-halt memory readout controller for the FPGA board wrapper. Owns the system_if

---
 rtl/debug_mem_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_debug_mem_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_mem_sequencer.sv
// debug_mem_sequencer
// Takes over the memory port once the CPU halts and reads words one at a time for the
// board display. The start address comes from switches. Reads advance on a debounced key
// press or on an auto-scan dwell timer. The captured word and its address feed the
// HEX/LED display.

module debug_mem_sequencer #(
    parameter int unsigned RAM_LAT      = 2,
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned DWELL_CYC    = 50000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        step_n,
    input  logic        auto_en,
    input  logic [15:0] base_addr,
    input  logic [31:0] load,
    output logic        tbCTRL,
    output logic        REN,
    output logic [31:0] addr,
    output logic [31:0] disp_data,
    output logic [15:0] disp_addr,
    output logic        disp_valid,
    output logic        busy
);

    localparam int unsigned LatW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam int unsigned DbW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned DwW  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    localparam logic [LatW-1:0] LatLast = LatW'(RAM_LAT - 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYC - 1);
    localparam logic [DwW-1:0]  DwLast  = DwW'(DWELL_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRead,
        StCapture,
        StHold
    } state_e;

    state_e state_q, state_d;

    // Key synchronizer and debouncer
    logic [1:0]     key_sync_q;
    logic           key_s;
    logic           db_level_q, db_level_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           press_q, press_d;

    // Datapath: current word index, base snapshot, latency and dwell counters
    logic [13:0]    cur_q, cur_d;
    logic [13:0]    bsnap_q, bsnap_d;
    logic [LatW-1:0] lat_q, lat_d;
    logic [DwW-1:0] dwell_q, dwell_d;

    // Next values of the registered outputs
    logic           tbctrl_d, ren_d, busy_d, disp_valid_d;
    logic [31:0]    disp_data_d;
    logic [15:0]    disp_addr_d;

    logic           restart;
    logic           advance;

    // Byte-select bits of the switch address have no meaning for word reads.
    logic           unused_base_lo;
    assign unused_base_lo = ^base_addr[1:0];

    assign key_s   = key_sync_q[1];
    assign restart = (base_addr[15:2] != bsnap_q);
    assign advance = auto_en ? (dwell_q == DwLast) : press_q;
    assign addr    = {16'h0000, cur_q, 2'b00};

    // Two-flop synchronizer for the raw key; released (1) out of reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            key_sync_q <= 2'b11;
        end else begin
            key_sync_q <= {key_sync_q[0], step_n};
        end
    end

    // Debounce: accept a new level after DEBOUNCE_CYC consecutive differing samples
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (key_s != db_level_q) begin
            if (db_cnt_q == DbLast) begin
                db_level_d = key_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_d = db_level_q & ~db_level_d;
    end

    // Debounced level, its stability counter and the one-cycle press pulse
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            db_level_q <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; losing halt overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d = StRead;
            end
            StRead: begin
                if (lat_q == LatLast) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d = StHold;
            end
            StHold: begin
                // A new start address wins over a pending advance
                if (restart) begin
                    state_d = StArm;
                end else if (advance) begin
                    state_d = StRead;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (!halt) begin
            state_d = StIdle;
        end
    end

    // FSM outputs and datapath next values, keyed on the transition being taken
    always_comb begin
        cur_d        = cur_q;
        bsnap_d      = bsnap_q;
        lat_d        = '0;
        dwell_d      = '0;
        disp_data_d  = disp_data;
        disp_addr_d  = disp_addr;
        disp_valid_d = disp_valid;
        tbctrl_d     = (state_d != StIdle);
        ren_d        = (state_d == StRead);
        busy_d       = (state_d == StRead);
        unique case (state_q)
            StArm: begin
                if (state_d == StRead) begin
                    cur_d        = base_addr[15:2];
                    bsnap_d      = base_addr[15:2];
                    disp_valid_d = 1'b0;
                end
            end
            StRead: begin
                if (state_d == StRead) begin
                    lat_d = lat_q + 1'b1;
                end else if (state_d == StCapture) begin
                    // load is valid on the last latency cycle only
                    disp_data_d  = load;
                    disp_addr_d  = {cur_q, 2'b00};
                    disp_valid_d = 1'b1;
                end
            end
            StHold: begin
                if (state_d == StHold && auto_en) begin
                    dwell_d = dwell_q + 1'b1;
                end
                if (state_d == StRead) begin
                    // 14-bit word index: 0xFFFC wraps to 0x0000
                    cur_d = cur_q + 14'd1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_q   <= '0;
            bsnap_q <= '0;
            lat_q   <= '0;
            dwell_q <= '0;
        end else begin
            cur_q   <= cur_d;
            bsnap_q <= bsnap_d;
            lat_q   <= lat_d;
            dwell_q <= dwell_d;
        end
    end

    // Registered outputs
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tbCTRL     <= 1'b0;
            REN        <= 1'b0;
            busy       <= 1'b0;
            disp_data  <= '0;
            disp_addr  <= '0;
            disp_valid <= 1'b0;
        end else begin
            tbCTRL     <= tbctrl_d;
            REN        <= ren_d;
            busy       <= busy_d;
            disp_data  <= disp_data_d;
            disp_addr  <= disp_addr_d;
            disp_valid <= disp_valid_d;
        end
    end

endmodule

// File: tb/tb_debug_mem_sequencer.sv
// Bench for debug_mem_sequencer: reset, manual stepping with debounce, auto-scan with wrap,
// base restarts, halt drop and asynchronous reset, checked against an address/data model.

module tb_debug_mem_sequencer;

    localparam int unsigned RAM_LAT      = 2;
    localparam int unsigned DEBOUNCE_CYC = 16;
    localparam int unsigned DWELL_CYC    = 8;
    localparam int          Spacing      = DWELL_CYC + RAM_LAT + 1;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        halt = 1'b1;
    logic        step_n = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] base_addr = 16'h0040;
    logic [31:0] load;
    logic        tbCTRL, REN, disp_valid, busy;
    logic [31:0] addr, disp_data;
    logic [15:0] disp_addr;

    debug_mem_sequencer #(
        .RAM_LAT     (RAM_LAT),
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .DWELL_CYC   (DWELL_CYC)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .halt      (halt),
        .step_n    (step_n),
        .auto_en   (auto_en),
        .base_addr (base_addr),
        .load      (load),
        .tbCTRL    (tbCTRL),
        .REN       (REN),
        .addr      (addr),
        .disp_data (disp_data),
        .disp_addr (disp_addr),
        .disp_valid(disp_valid),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Memory contents: a fixed pattern per address plus the known word at 0x40
    function automatic logic [31:0] data_of(input logic [15:0] a);
        if (a == 16'h0040) return 32'hDEADBEEF;
        return {a ^ 16'h5A5A, ~a};
    endfunction

    // RAM: data is valid only on the RAM_LAT-th cycle of a REN burst, garbage otherwise
    int ren_cyc = 0;
    always @(posedge CLK) ren_cyc <= REN ? ren_cyc + 1 : 0;
    always_comb load = (REN && ren_cyc == int'(RAM_LAT) - 1) ? data_of(addr[15:0])
                                                             : 32'hBAD0_BAD0;

    // Read monitor: counts bursts, their lengths, start cycle, address and valid at start
    int          starts = 0;
    int          dones = 0;
    int          ncyc = 0;
    int          cur_len = 0;
    int          last_len = 0;
    int          rise_cyc = 0;
    logic        ren_prev = 1'b0;
    logic [31:0] rise_addr = '0;
    logic        rise_valid = 1'b0;

    always @(negedge CLK) begin
        ncyc     <= ncyc + 1;
        ren_prev <= REN;
        if (REN && !ren_prev) begin
            starts     <= starts + 1;
            rise_cyc   <= ncyc;
            rise_addr  <= addr;
            rise_valid <= disp_valid;
            cur_len    <= 1;
        end else if (REN) begin
            cur_len <= cur_len + 1;
        end
        if (!REN && ren_prev) begin
            dones    <= dones + 1;
            last_len <= cur_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (dones > d0) break;
            tick(1);
        end
        check({tag, " done"}, dones, d0 + 1);
    endtask

    task automatic wait_start(input int s0, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (starts > s0) break;
            tick(1);
        end
        check({tag, " start"}, starts, s0 + 1);
    endtask

    task automatic check_capture(input string tag, input logic [15:0] a);
        check({tag, " addr"}, {16'h0, disp_addr}, {16'h0, a});
        check({tag, " data"}, disp_data, data_of(a));
        check({tag, " valid"}, {31'h0, disp_valid}, 32'd1);
        check({tag, " ren_len"}, last_len, RAM_LAT);
        check({tag, " bus_addr"}, rise_addr, {16'h0, a});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " tbCTRL"}, {31'h0, tbCTRL}, 32'd0);
        check({tag, " REN"}, {31'h0, REN}, 32'd0);
        check({tag, " addr"}, addr, 32'd0);
        check({tag, " disp_data"}, disp_data, 32'd0);
        check({tag, " disp_addr"}, {16'h0, disp_addr}, 32'd0);
        check({tag, " disp_valid"}, {31'h0, disp_valid}, 32'd0);
        check({tag, " busy"}, {31'h0, busy}, 32'd0);
    endtask

    logic [15:0] exp_addr;
    logic [15:0] nb;
    int          d0, s0, t_prev, lo, hi;
    bit          is_press;

    initial begin
        // Reset held with halt high and key pressed
        repeat (3) @(posedge CLK);
        #1;
        check_all_zero("reset");
        step_n = 1'b1;
        tick(2);
        d0 = dones;
        @(negedge CLK);
        nRST = 1'b1;
        wait_done(d0, 30, "first read");
        exp_addr = 16'h0040;
        check_capture("first read", exp_addr);
        check("hold tbCTRL", {31'h0, tbCTRL}, 32'd1);
        check("hold REN", {31'h0, REN}, 32'd0);
        check("hold busy", {31'h0, busy}, 32'd0);

        // Short glitch must not advance; a long press advances exactly once
        s0 = starts;
        step_n = 1'b0;
        tick(5);
        step_n = 1'b1;
        tick(40);
        check("glitch ignored", starts, s0);
        d0 = dones;
        step_n = 1'b0;
        tick(20);
        step_n = 1'b1;
        wait_done(d0, 40, "press");
        exp_addr = exp_addr + 16'd4;
        check_capture("press", exp_addr);
        s0 = starts;
        tick(40);
        check("single advance", starts, s0);

        // Random presses and glitches
        for (int i = 0; i < 8; i++) begin
            is_press = ($urandom_range(0, 1) == 1);
            lo = is_press ? $urandom_range(20, 40) : $urandom_range(1, 10);
            hi = $urandom_range(25, 40);
            d0 = dones;
            s0 = starts;
            step_n = 1'b0;
            tick(lo);
            step_n = 1'b1;
            tick(hi);
            if (is_press) begin
                exp_addr = exp_addr + 16'd4;
                wait_done(d0, 10, "rnd press");
                check_capture("rnd press", exp_addr);
            end else begin
                check("rnd glitch", starts, s0);
            end
        end

        // Changing only the byte-select bits does not restart
        s0 = starts;
        base_addr = {base_addr[15:2], 2'b11};
        tick(30);
        check("base lo bits", starts, s0);

        // Base change in HOLD restarts at the new base with valid cleared during the read
        d0 = dones;
        base_addr = 16'h0100;
        wait_done(d0, 20, "base change");
        check("base change valid", {31'h0, rise_valid}, 32'd0);
        exp_addr = 16'h0100;
        check_capture("base change", exp_addr);

        for (int i = 0; i < 3; i++) begin
            nb = 16'($urandom);
            while (nb[15:2] == exp_addr[15:2] || nb[15:2] == 14'h3FFF) nb = 16'($urandom);
            d0 = dones;
            base_addr = nb;
            wait_done(d0, 20, "rnd base");
            exp_addr = nb & 16'hFFFC;
            check_capture("rnd base", exp_addr);
        end

        // Auto-scan from the top of the address space, with wrap and fixed spacing
        d0 = dones;
        base_addr = 16'hFFFF;
        auto_en = 1'b1;
        wait_done(d0, 20, "auto first");
        check_capture("auto first", 16'hFFFC);
        t_prev = rise_cyc;
        d0 = dones;
        wait_done(d0, Spacing + 10, "auto wrap");
        check_capture("auto wrap", 16'h0000);
        check("auto spacing 1", rise_cyc - t_prev, Spacing);
        t_prev = rise_cyc;
        d0 = dones;
        wait_done(d0, Spacing + 10, "auto next");
        check_capture("auto next", 16'h0004);
        check("auto spacing 2", rise_cyc - t_prev, Spacing);
        exp_addr = 16'h0004;

        // Back to manual: no advance; short auto bursts never reach the dwell
        auto_en = 1'b0;
        s0 = starts;
        tick(30);
        check("manual hold", starts, s0);
        for (int i = 0; i < 3; i++) begin
            auto_en = 1'b1;
            tick(DWELL_CYC - 2);
            auto_en = 1'b0;
            tick(2);
            check("auto toggle", starts, s0);
        end

        // Halt drop on the last read cycle aborts the read; display holds
        s0 = starts;
        auto_en = 1'b1;
        wait_start(s0, 20, "halt drop");
        halt = 1'b0;
        auto_en = 1'b0;
        tick(1);
        check("halt drop tbCTRL", {31'h0, tbCTRL}, 32'd0);
        check("halt drop REN", {31'h0, REN}, 32'd0);
        check("halt drop busy", {31'h0, busy}, 32'd0);
        check("halt drop data", disp_data, data_of(exp_addr));
        check("halt drop addr", {16'h0, disp_addr}, {16'h0, exp_addr});
        check("halt drop valid", {31'h0, disp_valid}, 32'd1);
        tick(20);
        check("idle no reads", starts, s0 + 1);
        check("idle tbCTRL", {31'h0, tbCTRL}, 32'd0);

        // Halt re-rise reads the base again
        base_addr = 16'h0200;
        d0 = dones;
        halt = 1'b1;
        wait_done(d0, 20, "rehalt");
        check("rehalt valid", {31'h0, rise_valid}, 32'd0);
        exp_addr = 16'h0200;
        check_capture("rehalt", exp_addr);

        // Async reset in the middle of a read
        s0 = starts;
        base_addr = 16'h0300;
        wait_start(s0, 20, "reset mid");
        #2;
        nRST = 1'b0;
        #1;
        check_all_zero("reset mid");
        tick(2);
        check_all_zero("reset held");
        d0 = dones;
        @(negedge CLK);
        nRST = 1'b1;
        wait_done(d0, 20, "after reset");
        check_capture("after reset", 16'h0300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
